mem_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arb_wdog.sv | 35 +++
 rtl/mem_arbiter.sv | 104 ++++++++++
 tb/tb_mem_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_e;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

  // Watchdog counter width able to hold TIMEOUT-1, never narrower than 8 bits.
  function automatic int WDOG_W(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w < 8) ? 8 : w;
  endfunction

endpackage

// File: rtl/mem_arb_wdog.sv
// Busy-cycle watchdog: cleared while idle, counts stalled cycles, flags the last allowed one.
module mem_arb_wdog
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = WDOG_W(TIMEOUT);
  localparam logic [W-1:0] LIMIT = (TIMEOUT == 0) ? {W{1'b0}} : W'(TIMEOUT - 1);
  localparam logic [W-1:0] ONE   = W'(1);

  logic [W-1:0] count_r;

  // Stall counter; restarts on every new grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r <= {W{1'b0}};
    end else if (clr) begin
      count_r <= {W{1'b0}};
    end else if (en) begin
      count_r <= count_r + ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (TIMEOUT != 0) && (count_r == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter sharing one slave port, with a transaction watchdog.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [31:0] m0_addr,
  output logic [31:0] m0_rdata,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [31:0] m1_addr,
  output logic [31:0] m1_rdata,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        s_valid,
  input  logic        s_ready,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic [31:0] s_rdata,
  output logic        timeout_err,
  output logic [31:0] err_addr
);

  arb_state_e  state_r;
  logic        grant_r;
  logic        last_r;
  logic [31:0] err_addr_r;

  logic        busy_s;
  logic        expired_s;
  logic        abort_s;
  logic        finish_s;
  logic        pick_s;
  logic [31:0] resp_s;

  assign busy_s   = (state_r == BUSY);
  assign abort_s  = busy_s && !s_ready && expired_s;
  assign finish_s = busy_s && (s_ready || abort_s);
  // On a tie the master that did not win last time gets the port.
  assign pick_s   = (m0_valid && m1_valid) ? ~last_r : m1_valid;
  assign resp_s   = abort_s ? ERR_DATA : s_rdata;

  mem_arb_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_r == IDLE),
    .en      (busy_s && !s_ready),
    .expired (expired_s)
  );

  // Arbitration FSM: grant in IDLE, hold through BUSY, one dead DONE cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      grant_r    <= 1'b0;
      last_r     <= 1'b1;
      err_addr_r <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (m0_valid || m1_valid) begin
            grant_r <= pick_s;
            last_r  <= pick_s;
            state_r <= BUSY;
          end
        end
        BUSY: begin
          if (s_ready) begin
            state_r <= DONE;
          end else if (abort_s) begin
            err_addr_r <= s_addr;
            state_r    <= DONE;
          end
        end
        DONE:    state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

  assign s_valid  = busy_s;
  assign s_addr   = !busy_s ? 32'd0 : (grant_r ? m1_addr  : m0_addr);
  assign s_wdata  = !busy_s ? 32'd0 : (grant_r ? m1_wdata : m0_wdata);
  assign s_wstrb  = !busy_s ? 4'd0  : (grant_r ? m1_wstrb : m0_wstrb);

  assign m0_ready = finish_s && !grant_r;
  assign m1_ready = finish_s && grant_r;
  assign m0_rdata = (busy_s && !grant_r) ? resp_s : 32'd0;
  assign m1_rdata = (busy_s && grant_r)  ? resp_s : 32'd0;

  assign timeout_err = abort_s;
  assign err_addr    = err_addr_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter: two random masters, a random-latency slave, a monitor.
module tb_mem_arbiter;

  localparam int          TMO = 8;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  typedef struct {
    bit ok;
    int r;
  } out_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        m0_valid = 1'b0, m1_valid = 1'b0;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_addr = 32'd0, m1_addr = 32'd0;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] m0_wdata = 32'd0, m1_wdata = 32'd0;
  logic [3:0]  m0_wstrb = 4'd0, m1_wstrb = 4'd0;
  logic        s_valid;
  logic        s_ready = 1'b0;
  logic [31:0] s_addr, s_wdata, s_rdata_d;
  logic [3:0]  s_wstrb;
  logic [31:0] s_rdata = 32'd0;
  logic        timeout_err;
  logic [31:0] err_addr;

  int passed = 0;
  int total  = 0;

  req_t q0[$];
  req_t q1[$];
  out_t outq[$];

  bit mon_en = 1'b0;
  bit mute   = 1'b0;

  mem_arbiter #(.TIMEOUT(TMO), .ERR_DATA(ERR)) dut (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr), .m0_rdata(m0_rdata),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr), .m1_rdata(m1_rdata),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_rdata(s_rdata), .timeout_err(timeout_err), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, passed %0d of %0d", passed, total);
    $fatal(1);
  end

  function automatic logic [31:0] slave_data(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3C3_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Random master: issues n requests, holds valid until ready, random idle gap between them.
  task automatic master(input bit k, input int n);
    req_t        r;
    logic [31:0] a;
    bit          got;
    int          gap;
    for (int i = 0; i < n; i++) begin
      a = $urandom();
      a[31] = k;
      r.addr = a;
      r.wdata = $urandom();
      r.wstrb = 4'($urandom_range(0, 15));
      if (k) begin
        m1_addr = r.addr; m1_wdata = r.wdata; m1_wstrb = r.wstrb; m1_valid = 1'b1;
        q1.push_back(r);
      end else begin
        m0_addr = r.addr; m0_wdata = r.wdata; m0_wstrb = r.wstrb; m0_valid = 1'b1;
        q0.push_back(r);
      end
      got = 1'b0;
      for (int c = 0; c < 300 && !got; c++) begin
        @(negedge clk);
        got = k ? m1_ready : m0_ready;
      end
      check(k ? "m1_ready_wait" : "m0_ready_wait", got, 1'b1);
      @(posedge clk); #1;
      a = $urandom();
      if (k) begin m1_valid = 1'b0; m1_addr = a; m1_wdata = ~a; end
      else   begin m0_valid = 1'b0; m0_addr = a; m0_wdata = ~a; end
      gap = $urandom_range(0, 3);
      repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  // Slave model: picks a completion cycle per transaction, possibly never answering.
  int sc = 0;
  int sr = 0;
  always @(posedge clk) begin
    int sel;
    out_t o;
    #1;
    if (!rst || mute || !s_valid) begin
      sc = 0;
      s_ready = 1'b0;
      s_rdata = $urandom();
    end else begin
      if (sc == 0) begin
        sel = $urandom_range(0, 9);
        if (sel <= 5)      sr = $urandom_range(1, 3);
        else if (sel == 6) sr = TMO - 1;
        else if (sel == 7) sr = TMO;
        else               sr = TMO + 3;
        o.ok = (sr <= TMO);
        o.r  = sr;
        outq.push_back(o);
      end
      sc++;
      s_ready = (sc == sr);
      s_rdata = s_ready ? slave_data(s_addr) : $urandom();
    end
  end

  // Monitor: arbitration order, mux contents, completion timing, response data and error report.
  bit          pv0 = 1'b0, pv1 = 1'b0;
  bit          last_m = 1'b1;
  bit          in_txn = 1'b0;
  int          cd = 100;
  int          bc = 0;
  req_t        cur;
  out_t        out;
  logic [31:0] err_model = 32'd0;
  always @(negedge clk) begin
    bit          g, rdy, have;
    logic [1:0]  eg;
    logic [31:0] rd;
    int          exp_done;
    if (cd < 100) cd++;
    if (mon_en && rst) begin
      check("err_addr", err_addr, err_model);
      if (s_valid) begin
        g = s_addr[31];
        if (!in_txn) begin
          in_txn = 1'b1;
          bc = 0;
          eg = (pv0 && pv1) ? {1'b0, ~last_m} : (pv1 ? 2'd1 : (pv0 ? 2'd0 : 2'd2));
          check("grant", {31'd0, g}, {30'd0, eg});
          last_m = g;
          check("grant_gap", cd >= 3, 1'b1);
          have = g ? (q1.size() > 0) : (q0.size() > 0);
          check("req_queued", have, 1'b1);
          cur = have ? (g ? q1[0] : q0[0]) : '0;
          check("slave_outcome", outq.size() > 0, 1'b1);
          if (outq.size() > 0) out = outq.pop_front();
          else begin out.ok = 1'b1; out.r = 1; end
        end
        bc++;
        check("s_addr", s_addr, cur.addr);
        check("s_wdata", s_wdata, cur.wdata);
        check("s_wstrb", {28'd0, s_wstrb}, {28'd0, cur.wstrb});
        if (g) begin
          check("m0_ready_idle", m0_ready, 1'b0);
          check("m0_rdata_idle", m0_rdata, 32'd0);
          rdy = m1_ready; rd = m1_rdata;
        end else begin
          check("m1_ready_idle", m1_ready, 1'b0);
          check("m1_rdata_idle", m1_rdata, 32'd0);
          rdy = m0_ready; rd = m0_rdata;
        end
        exp_done = out.ok ? out.r : TMO;
        check("ready_cycle", rdy, bc == exp_done);
        check("timeout_err", timeout_err, (bc == exp_done) && !out.ok);
        if (rdy) begin
          check("rdata", rd, out.ok ? slave_data(cur.addr) : ERR);
          if (g) begin if (q1.size() > 0) void'(q1.pop_front()); end
          else   begin if (q0.size() > 0) void'(q0.pop_front()); end
          if (!out.ok) err_model = cur.addr;
          in_txn = 1'b0;
          cd = 0;
        end
      end else begin
        check("busy_held", in_txn, 1'b0);
        in_txn = 1'b0;
        check("idle_s_addr", s_addr, 32'd0);
        check("idle_s_wdata", s_wdata, 32'd0);
        check("idle_s_wstrb", {28'd0, s_wstrb}, 32'd0);
        check("idle_ready", {m0_ready, m1_ready, timeout_err}, 32'd0);
        check("idle_rdata", m0_rdata | m1_rdata, 32'd0);
        check("missed_grant", (cd >= 3) && (pv0 || pv1), 1'b0);
      end
    end
    pv0 = m0_valid;
    pv1 = m1_valid;
  end

  initial begin
    bit got;
    fork
      master(1'b0, 30);
      master(1'b1, 30);
      begin
        repeat (3) @(negedge clk);
        #1;
        check("rst_s_valid", s_valid, 1'b0);
        check("rst_ready", {m0_ready, m1_ready, timeout_err}, 32'd0);
        check("rst_rdata", m0_rdata | m1_rdata, 32'd0);
        check("rst_s_bus", s_addr | s_wdata | {28'd0, s_wstrb}, 32'd0);
        check("rst_err_addr", err_addr, 32'd0);
        @(negedge clk); #2;
        rst = 1'b1;
        mon_en = 1'b1;
      end
    join
    repeat (4) @(negedge clk);
    check("q_drained", q0.size() + q1.size() + outq.size(), 32'd0);

    // Reset during BUSY, then a tie after release.
    mon_en = 1'b0;
    mute = 1'b1;
    @(posedge clk); #1;
    m0_addr = 32'h0000_0004; m0_wdata = 32'h1111_2222; m0_wstrb = 4'h3; m0_valid = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      got = s_valid;
    end
    check("rst_test_busy", got, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("midrst_s_valid", s_valid, 1'b0);
    check("midrst_ready", {m0_ready, m1_ready}, 32'd0);
    check("midrst_s_addr", s_addr, 32'd0);
    m1_addr = 32'h8000_0010; m1_wdata = 32'hA5A5_A5A5; m1_wstrb = 4'hF; m1_valid = 1'b1;
    @(negedge clk); #2;
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_s_valid", s_valid, 1'b1);
    check("post_rst_tie_m0", s_addr, 32'h0000_0004);
    check("post_rst_wdata", s_wdata, 32'h1111_2222);
    check("post_rst_m1_ready", m1_ready, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
